// File: rtl/spin_motor_ramp_controller_if.sv
// Signal bundle between the wash sequencer / spin-speed selector (master)
// and the spin motor ramp controller (slave).
interface spin_motor_ramp_controller_if;
    logic        start;
    logic        stop;
    logic        door_locked;
    logic [10:0] target_rpm;
    logic        imbalance;
    logic [10:0] motor_rpm;
    logic        motor_en;
    logic [2:0]  spin_state;
    logic        at_speed;
    logic        spin_done;
    logic        spin_aborted;

    modport master (
        output start, stop, door_locked, target_rpm, imbalance,
        input  motor_rpm, motor_en, spin_state, at_speed, spin_done, spin_aborted
    );

    modport slave (
        input  start, stop, door_locked, target_rpm, imbalance,
        output motor_rpm, motor_en, spin_state, at_speed, spin_done, spin_aborted
    );
endinterface

// File: rtl/spin_motor_ramp_controller.sv
// Drum motor speed command: rate-limited ramp up, timed hold, ramp down to stop.
// Optional imbalance restart logic is compiled in with SPIN_IMBALANCE_CHECK_EN.
module spin_motor_ramp_controller #(
    parameter int unsigned RAMP_STEP   = 50,
    parameter int unsigned TICK_DIV    = 10,
    parameter int unsigned HOLD_TICKS  = 20,
    parameter int unsigned MAX_RETRIES = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    spin_motor_ramp_controller_if.slave        bus
);
    localparam int unsigned RPM_W  = 11;
    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_HOLD      = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t             r_state, w_state_nx;
    logic [RPM_W-1:0]   r_rpm, w_rpm_nx;
    logic [RPM_W-1:0]   r_target, w_target_nx;
    logic [DIV_W-1:0]   r_presc, w_presc_nx;
    logic [HOLD_W-1:0]  r_hold, w_hold_nx;
    logic               r_aborted, w_aborted_nx;
    logic               r_motor_en, r_at_speed, r_spin_done;
    logic               w_tick, w_abort;
    logic [RPM_W:0]     w_up_sum;

`ifdef SPIN_IMBALANCE_CHECK_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 2);
    logic [RETRY_W-1:0] r_retry, w_retry_nx;
    logic               r_imb_down, w_imb_down_nx;
    logic               w_imb;
    assign w_imb = bus.imbalance;
`else
    logic w_unused;
    assign w_unused = bus.imbalance;
`endif

    assign w_tick   = (r_presc == DIV_W'(TICK_DIV - 1));
    assign w_abort  = bus.stop || !bus.door_locked;
    assign w_up_sum = {1'b0, r_rpm} + (RPM_W + 1)'(RAMP_STEP);

    // Next-state and datapath updates
    always_comb begin
        w_state_nx   = r_state;
        w_rpm_nx     = r_rpm;
        w_target_nx  = r_target;
        w_hold_nx    = r_hold;
        w_aborted_nx = r_aborted;
`ifdef SPIN_IMBALANCE_CHECK_EN
        w_retry_nx    = r_retry;
        w_imb_down_nx = r_imb_down;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.stop && bus.door_locked) begin
                    w_target_nx  = bus.target_rpm;
                    w_aborted_nx = 1'b0;
`ifdef SPIN_IMBALANCE_CHECK_EN
                    w_retry_nx    = '0;
                    w_imb_down_nx = 1'b0;
`endif
                    w_state_nx   = (bus.target_rpm == '0) ? S_DONE : S_RAMP_UP;
                end
            end
            S_RAMP_UP, S_HOLD: begin
                if (w_abort) begin
                    w_state_nx   = S_RAMP_DOWN;
                    w_aborted_nx = 1'b1;
`ifdef SPIN_IMBALANCE_CHECK_EN
                end else if (w_imb) begin
                    w_state_nx    = S_RAMP_DOWN;
                    w_imb_down_nx = 1'b1;
                    if (r_retry <= RETRY_W'(MAX_RETRIES))
                        w_retry_nx = r_retry + RETRY_W'(1);
`endif
                end else if (w_tick && (r_state == S_RAMP_UP)) begin
                    if (w_up_sum >= {1'b0, r_target}) begin
                        w_rpm_nx   = r_target;
                        w_state_nx = S_HOLD;
                    end else begin
                        w_rpm_nx = w_up_sum[RPM_W-1:0];
                    end
                end else if (w_tick) begin
                    if (r_hold == HOLD_W'(HOLD_TICKS - 1))
                        w_state_nx = S_RAMP_DOWN;
                    else
                        w_hold_nx = r_hold + HOLD_W'(1);
                end
            end
            S_RAMP_DOWN: begin
                if (w_tick) begin
                    if ({1'b0, r_rpm} > (RPM_W + 1)'(RAMP_STEP)) begin
                        w_rpm_nx = r_rpm - RPM_W'(RAMP_STEP);
                    end else begin
                        w_rpm_nx   = '0;
                        w_state_nx = S_DONE;
`ifdef SPIN_IMBALANCE_CHECK_EN
                        // Imbalance-driven stop: restart the same target until retries run out
                        if (r_imb_down && !r_aborted) begin
                            w_imb_down_nx = 1'b0;
                            if (r_retry <= RETRY_W'(MAX_RETRIES))
                                w_state_nx = S_RAMP_UP;
                            else
                                w_aborted_nx = 1'b1;
                        end
`endif
                    end
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase

        // Prescaler and hold counter restart on every state entry
        w_presc_nx = (w_tick || (w_state_nx != r_state)) ? '0 : r_presc + DIV_W'(1);
        if (w_state_nx != r_state)
            w_hold_nx = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rpm       <= '0;
            r_target    <= '0;
            r_presc     <= '0;
            r_hold      <= '0;
            r_aborted   <= 1'b0;
            r_motor_en  <= 1'b0;
            r_at_speed  <= 1'b0;
            r_spin_done <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_rpm       <= w_rpm_nx;
            r_target    <= w_target_nx;
            r_presc     <= w_presc_nx;
            r_hold      <= w_hold_nx;
            r_aborted   <= w_aborted_nx;
            r_motor_en  <= (w_state_nx == S_RAMP_UP) || (w_state_nx == S_HOLD) ||
                           (w_state_nx == S_RAMP_DOWN);
            r_at_speed  <= (w_state_nx == S_HOLD);
            r_spin_done <= (w_state_nx == S_DONE);
        end
    end

`ifdef SPIN_IMBALANCE_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retry    <= '0;
            r_imb_down <= 1'b0;
        end else begin
            r_retry    <= w_retry_nx;
            r_imb_down <= w_imb_down_nx;
        end
    end
`endif

    assign bus.motor_rpm    = r_rpm;
    assign bus.motor_en     = r_motor_en;
    assign bus.spin_state   = r_state;
    assign bus.at_speed     = r_at_speed;
    assign bus.spin_done    = r_spin_done;
    assign bus.spin_aborted = r_aborted;
endmodule

// File: tb/tb_spin_motor_ramp_controller.sv
// Bench for spin_motor_ramp_controller: expected per-cycle output traces are
// generated from the ramp/hold/abort rules and compared every clock.
module tb_spin_motor_ramp_controller;
    localparam int TD = 2;
    localparam int S  = 50;
    localparam int HT = 3;
    localparam int MR = 2;

    logic clk = 1'b0;
    logic reset;

    spin_motor_ramp_controller_if bus();

    spin_motor_ramp_controller #(
        .RAMP_STEP   (S),
        .TICK_DIV    (TD),
        .HOLD_TICKS  (HT),
        .MAX_RETRIES (MR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [10:0] rpm;
        logic        en;
        logic        at;
        logic        done;
        logic        ab;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic model_ab = 1'b0;

    function automatic obs_t mk(int st, int rpm, logic ab);
        obs_t e;
        e.st   = 3'(st);
        e.rpm  = 11'(rpm);
        e.en   = (st >= 1) && (st <= 3);
        e.at   = (st == 2);
        e.done = (st == 4);
        e.ab   = ab;
        return e;
    endfunction

    // Ramp up from 0: one tick every TD cycles, rpm shows k*S during tick interval k
    function automatic void push_up(int t, int n_max);
        int cnt = 0;
        for (int g = 0; g * S < t; g++)
            for (int k = 0; k < TD; k++)
                if (cnt < n_max) begin
                    exp_q.push_back(mk(1, g * S, model_ab));
                    cnt++;
                end
    endfunction

    function automatic void push_hold(int t, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(2, t, model_ab));
    endfunction

    // Ramp down always takes at least one tick, even from 0
    function automatic void push_down(int r);
        int v = r;
        do begin
            for (int k = 0; k < TD; k++) exp_q.push_back(mk(3, v, model_ab));
            v = (v > S) ? v - S : 0;
        end while (v > 0);
    endfunction

    function automatic void push_done();
        exp_q.push_back(mk(4, 0, model_ab));
    endfunction

    function automatic void push_idle(int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 0, model_ab));
    endfunction

    function automatic void build_normal(int t);
        push_up(t, 1 << 30);
        push_hold(t, HT * TD);
        push_down(t);
        push_done();
        push_idle(2);
    endfunction

    function automatic int up_len(int t);
        return ((t + S - 1) / S) * TD;
    endfunction

    task automatic check_sample(string tag);
        obs_t o, e;
        o = {bus.spin_state, bus.motor_rpm, bus.motor_en, bus.at_speed,
             bus.spin_done, bus.spin_aborted};
        e = exp_q.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed st=%0d rpm=%0d en=%b at=%b done=%b ab=%b expected st=%0d rpm=%0d en=%b at=%b done=%b ab=%b",
                   tag, o.st, o.rpm, o.en, o.at, o.done, o.ab,
                   e.st, e.rpm, e.en, e.at, e.done, e.ab);
        end
    endtask

    task automatic start_spin(int t);
        bus.target_rpm  = 11'(t);
        bus.start       = 1'b1;
        bus.stop        = 1'b0;
        bus.door_locked = 1'b1;
        model_ab        = 1'b0;
    endtask

    // Step through the expected trace; selector input wanders to prove it was latched
    task automatic run_trace(string tag, int n_lim, int abort_at, bit abort_door,
                             int imb0, int imb1, int imb2);
        int n = exp_q.size();
        if (n_lim < n) n = n_lim;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.start      = 1'b0;
            bus.target_rpm = 11'($urandom_range(0, 2047));
            check_sample(tag);
            bus.stop        = (i == abort_at) && !abort_door;
            bus.door_locked = !((i == abort_at) && abort_door);
            bus.imbalance   = (i == imb0) || (i == imb1) || (i == imb2);
        end
        bus.stop        = 1'b0;
        bus.door_locked = 1'b1;
        bus.imbalance   = 1'b0;
    endtask

    initial begin
        int t, k, kind, i0, i1, i2;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.door_locked = 1'b1;
        bus.target_rpm  = '0;
        bus.imbalance   = 1'b0;
        reset           = 1'b0;
        #1 reset = 1'b1;
        #1;
        push_idle(1);
        check_sample("reset_state");
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        push_idle(1);
        check_sample("idle_after_reset");

        // Nominal spin to 400 with selector changing underneath
        start_spin(400);
        build_normal(400);
        run_trace("spin_400", 1 << 30, -1, 1'b0, -1, -1, -1);

        // Non-multiple target: last up step is a partial one
        start_spin(425);
        build_normal(425);
        run_trace("spin_425", 1 << 30, -1, 1'b0, -1, -1, -1);

        // Stop pulsed while commanded speed is 200 on the way up
        start_spin(400);
        k = (200 / S) * TD;
        push_up(400, k + 1);
        model_ab = 1'b1;
        push_down(200);
        push_done();
        push_idle(2);
        run_trace("stop_at_200", 1 << 30, k, 1'b0, -1, -1, -1);

        // Door open: start refused, abort flag still sticky
        bus.target_rpm  = 11'd300;
        bus.start       = 1'b1;
        bus.door_locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            push_idle(1);
            check_sample("door_open_start");
        end
        // Stop wins over start in IDLE
        bus.door_locked = 1'b1;
        bus.stop        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            push_idle(1);
            check_sample("stop_over_start");
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // Zero target: straight to DONE, motor never enabled
        start_spin(0);
        push_done();
        push_idle(2);
        run_trace("target_zero", 1 << 30, -1, 1'b0, -1, -1, -1);

        // Randomized targets with optional stop / door aborts during ramp up or hold
        for (int r = 0; r < 6; r++) begin
            t    = int'($urandom_range(1, 2047));
            kind = int'($urandom_range(0, 2));
            start_spin(t);
            if (kind == 0) begin
                build_normal(t);
                run_trace("rand_normal", 1 << 30, -1, 1'b0, -1, -1, -1);
            end else begin
                k = int'($urandom_range(0, up_len(t) + HT * TD - 1));
                push_up(t, k + 1);
                if (k >= up_len(t)) push_hold(t, k + 1 - up_len(t));
                model_ab = 1'b1;
                push_down((k < up_len(t)) ? (k / TD) * S : t);
                push_done();
                push_idle(2);
                run_trace((kind == 1) ? "rand_stop" : "rand_door", 1 << 30, k,
                          (kind == 2), -1, -1, -1);
            end
        end

        // Imbalance pulsed three times in HOLD at target 400
        start_spin(400);
        i0 = up_len(400);
        i1 = i0 + 1 + up_len(400) + up_len(400);
        i2 = i1 + 1 + up_len(400) + up_len(400);
`ifdef SPIN_IMBALANCE_CHECK_EN
        for (int n = 0; n < 3; n++) begin
            push_up(400, 1 << 30);
            push_hold(400, 1);
            push_down(400);
        end
        model_ab = 1'b1;
        push_done();
        push_idle(2);
`else
        build_normal(400);
`endif
        run_trace("imbalance", 1 << 30, -1, 1'b0, i0, i1, i2);

        // Asynchronous reset in the middle of a ramp
        start_spin(800);
        build_normal(800);
        run_trace("pre_reset_spin", 12, -1, 1'b0, -1, -1, -1);
        exp_q.delete();
        #3 reset = 1'b1;
        #1;
        model_ab = 1'b0;
        push_idle(1);
        check_sample("mid_spin_reset");
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        push_idle(1);
        check_sample("idle_after_mid_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spin_motor_ramp_controller.md
# spin_motor_ramp_controller

Downstream consumer of the spin-speed selector: latches the selected spin speed at spin start and drives the drum motor speed command with a rate-limited ramp up, a timed hold at speed, and a ramp down to stop. Sits between the spin-speed selector output and the motor driver interface, under the control of the main wash sequencer.

## Interface
- `RAMP_STEP`, 50: rpm added/removed per ramp tick.
- `TICK_DIV`, 10: clock cycles per ramp tick (≥1).
- `HOLD_TICKS`, 20: ticks spent in HOLD at target speed (≥1).
- `MAX_RETRIES`, 2: imbalance restarts allowed (used only with the imbalance-check feature).

- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a spin cycle; sampled in IDLE only.
- `stop` in 1: abort request; level-sensitive.
- `door_locked` in 1: door interlock; must be 1 for the block to start or keep spinning.
- `target_rpm` in 11: spin speed from the selector (0–2047 rpm).
- `imbalance` in 1: drum imbalance detect; ignored unless the feature is compiled in.
- `motor_rpm` out 11: commanded motor speed.
- `motor_en` out 1: motor driver enable.
- `spin_state` out 3: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, DONE=4.
- `at_speed` out 1: high only in HOLD.
- `spin_done` out 1: one-cycle pulse in DONE.
- `spin_aborted` out 1: sticky; set on abort or fault, cleared on the next accepted start.

## Operation
- IDLE: when `start`=1 and `door_locked`=1, latch `target_rpm` into an internal register and go to RAMP_UP; if the latched value is 0, go to DONE instead. Later changes to `target_rpm` are ignored until the next start.
- RAMP_UP: on each tick, `motor_rpm` = min(`motor_rpm` + RAMP_STEP, target), computed 12 bits wide with no overflow. On the tick that reaches the target, move to HOLD on the same edge.
- HOLD: count HOLD_TICKS ticks, then go to RAMP_DOWN.
- RAMP_DOWN: on each tick, `motor_rpm` = (`motor_rpm` > RAMP_STEP) ? `motor_rpm` − RAMP_STEP : 0. On the tick that reaches 0, go to DONE.
- DONE: lasts one cycle with `spin_done`=1, then returns to IDLE.
- Abort: `stop`=1 or `door_locked`=0 in RAMP_UP or HOLD forces RAMP_DOWN on the next edge and sets `spin_aborted`. RAMP_DOWN always runs to 0; there is never an instant stop. DONE is still reached and `spin_done` still pulses.
- `start` is ignored outside IDLE. `stop` takes priority over `start` in IDLE (no start accepted).
- `motor_en` = 1 in RAMP_UP, HOLD and RAMP_DOWN; 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE, `motor_rpm`=0, `motor_en`=0, `at_speed`=0, `spin_done`=0, `spin_aborted`=0. Prescaler and hold counter are cleared.
- Reset mid-spin: all outputs return to reset values asynchronously, including `motor_rpm`, which drops to 0 immediately.
- The tick prescaler is cleared on every state entry. The first tick fires TICK_DIV cycles after entry.
- `start` sampled at edge N gives RAMP_UP and `motor_en`=1 from N+1. The first `motor_rpm` change occurs at edge N+TICK_DIV.
- A full cycle to target T takes ceil(T/RAMP_STEP) ticks up, HOLD_TICKS ticks in hold, ceil(T/RAMP_STEP) ticks down, plus 1 cycle in DONE.
- Outputs are all registered and change only on `clk` edges, except during reset.

## Configuration
- `SPIN_IMBALANCE_CHECK_EN` defined:
  - `imbalance`=1 in RAMP_UP or HOLD forces RAMP_DOWN and increments a retry counter.
  - On reaching 0, the block re-enters RAMP_UP with the same target while retries ≤ MAX_RETRIES.
  - Otherwise it goes to DONE with `spin_aborted`=1.
  - The retry counter is cleared on an accepted start.
- Not defined: `imbalance` is ignored; no retry logic is synthesized.

## Test plan
Bench parameters: TICK_DIV=2, RAMP_STEP=50, HOLD_TICKS=3.
- Reset, then start with target 400: `motor_rpm` steps 50…400 every 2 cycles, HOLD for 6 cycles with `at_speed`=1, steps down to 0, one-cycle `spin_done`, `spin_aborted`=0.
- Target 425: ramp ends 400→425 on the 9th tick. Ramp down goes 375…25→0.
- Change `target_rpm` from 400 to 1000 during RAMP_UP: the ramp still stops at 400.
- `stop` pulsed at `motor_rpm`=200 during ramp up: RAMP_DOWN to 0, `spin_done` pulses, `spin_aborted`=1 until the next start.
- Start with `door_locked`=0: the block stays in IDLE. Start with target 0: DONE next cycle, `motor_en` never asserted.
- With `SPIN_IMBALANCE_CHECK_EN` and target 400: `imbalance` pulsed 3 times in HOLD gives 2 full re-ramps, then DONE with `spin_aborted`=1. Without the macro, the same stimulus gives a normal cycle.
